fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/fifo_rd_ctrl.sv | 116 +++++++++++
 tb/tb_fifo_rd_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO read controller: FSM state encoding and byte width.
package fifo_rd_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    ACK   = 2'd2,
    DRAIN = 2'd3
  } rdState_e;

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Pops words from a first-word-fall-through FIFO and feeds them LSB byte first to a serial transmitter.
// Optional macro FIFO_RD_WORD_CNT_EN adds a 16-bit completed-word counter output O_WORD_CNT.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter  int WR_DATA_WIDTH = 16,
  localparam int NUM_BYTES     = WR_DATA_WIDTH / BYTE_W
) (
  input  logic                     I_CLK,
  input  logic                     I_RST,
  input  logic                     I_EN,
  input  logic                     I_EMPTY,
  input  logic [WR_DATA_WIDTH-1:0] I_RD_DATA,
  input  logic                     I_TX_BUSY,
  output logic                     O_R_INC,
  output logic [BYTE_W-1:0]        O_TX_DATA,
  output logic                     O_TX_VALID,
  output logic                     O_BUSY
`ifdef FIFO_RD_WORD_CNT_EN
  ,
  output logic [15:0]              O_WORD_CNT
`endif
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  rdState_e                 r_state;
  rdState_e                 w_next_state;
  logic [WR_DATA_WIDTH-1:0] r_word;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         w_next_idx;
  logic [BYTE_W-1:0]        r_tx_data;
  logic [BYTE_W-1:0]        w_next_byte;
  logic                     w_pop;
  logic                     w_advance;

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Pop is gated by reset so no strobe leaks out while the FSM is held in IDLE.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_advance    = 1'b0;
    O_TX_VALID   = 1'b0;
    case (r_state)
      IDLE: begin
        if (I_EN && !I_EMPTY && !I_RST) begin
          w_pop        = 1'b1;
          w_next_state = SEND;
        end
      end
      SEND: begin
        if (!I_TX_BUSY) begin
          O_TX_VALID   = 1'b1;
          w_next_state = ACK;
        end
      end
      ACK: begin
        if (I_TX_BUSY) w_next_state = DRAIN;
      end
      DRAIN: begin
        if (!I_TX_BUSY) begin
          if (r_idx < LAST_IDX) begin
            w_advance    = 1'b1;
            w_next_state = SEND;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_next_idx  = r_idx + IDX_W'(1);
  assign w_next_byte = r_word[{w_next_idx, 3'b000} +: BYTE_W];

  // The outgoing byte is loaded on entry to SEND so it is already stable when the strobe fires.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      r_word    <= '0;
      r_idx     <= '0;
      r_tx_data <= '0;
    end else if (w_pop) begin
      r_word    <= I_RD_DATA;
      r_idx     <= '0;
      r_tx_data <= I_RD_DATA[BYTE_W-1:0];
    end else if (w_advance) begin
      r_idx     <= w_next_idx;
      r_tx_data <= w_next_byte;
    end
  end

  assign O_R_INC   = w_pop;
  assign O_TX_DATA = r_tx_data;
  assign O_BUSY    = (r_state != IDLE);

`ifdef FIFO_RD_WORD_CNT_EN
  logic [15:0] r_word_cnt;
  logic        w_done;

  assign w_done = (r_state == DRAIN) && !I_TX_BUSY && (r_idx == LAST_IDX);

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST)       r_word_cnt <= '0;
    else if (w_done) r_word_cnt <= r_word_cnt + 16'd1;
  end

  assign O_WORD_CNT = r_word_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: FIFO and transmitter models, expected bytes queued at stimulus time.
module tb_fifo_rd_ctrl;

  logic        I_CLK;
  logic        I_RST;
  logic        I_EN;
  logic        I_EMPTY;
  logic [15:0] I_RD_DATA;
  logic        I_TX_BUSY;
  logic        O_R_INC;
  logic [7:0]  O_TX_DATA;
  logic        O_TX_VALID;
  logic        O_BUSY;
`ifdef FIFO_RD_WORD_CNT_EN
  logic [15:0] O_WORD_CNT;
`endif

  logic        txBusyModel;
  logic        stallBusy;
  logic [15:0] fifoQ[$];
  logic [7:0]  expQ[$];
  int          checks     = 0;
  int          failures   = 0;
  int          popCount   = 0;
  int          validCount = 0;
  int          cycle      = 0;
  int          popCycle   = 0;
  int          validCycle = 0;
  int          busyCycles = 10;

  assign I_TX_BUSY = txBusyModel | stallBusy;

  fifo_rd_ctrl #(.WR_DATA_WIDTH(16)) dut (
    .I_CLK      (I_CLK),
    .I_RST      (I_RST),
    .I_EN       (I_EN),
    .I_EMPTY    (I_EMPTY),
    .I_RD_DATA  (I_RD_DATA),
    .I_TX_BUSY  (I_TX_BUSY),
    .O_R_INC    (O_R_INC),
    .O_TX_DATA  (O_TX_DATA),
    .O_TX_VALID (O_TX_VALID),
    .O_BUSY     (O_BUSY)
`ifdef FIFO_RD_WORD_CNT_EN
    ,
    .O_WORD_CNT (O_WORD_CNT)
`endif
  );

  initial begin
    I_CLK = 1'b0;
    forever #5 I_CLK = ~I_CLK;
  end

  initial forever @(posedge I_CLK) cycle++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // FIFO model: head word is presented while non-empty, popped after a sampled O_R_INC
  initial begin : fifoModel
    logic doPop;
    I_EMPTY   = 1'b1;
    I_RD_DATA = 16'h0;
    forever begin
      @(negedge I_CLK);
      doPop = O_R_INC;
      @(posedge I_CLK);
      #1;
      if (doPop && fifoQ.size() > 0) void'(fifoQ.pop_front());
      I_EMPTY   = (fifoQ.size() == 0);
      I_RD_DATA = (fifoQ.size() > 0) ? fifoQ[0] : 16'h0;
    end
  end

  // Transmitter model: goes busy the cycle after each strobe for busyCycles cycles
  initial begin : txModel
    txBusyModel = 1'b0;
    forever begin
      @(negedge I_CLK);
      if (O_TX_VALID) begin
        @(posedge I_CLK);
        #1 txBusyModel = 1'b1;
        repeat (busyCycles) @(posedge I_CLK);
        #1 txBusyModel = 1'b0;
      end
    end
  end

  // Monitor: counts pops and compares every transmitted byte against the scoreboard
  initial begin : monitor
    logic [7:0] expByte;
    forever begin
      @(negedge I_CLK);
      if (O_R_INC) begin
        popCount++;
        popCycle = cycle;
      end
      if (O_TX_VALID) begin
        validCount++;
        validCycle = cycle;
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpectedByte: got 0x%0h expected no byte", O_TX_DATA);
        end else begin
          expByte = expQ.pop_front();
          checkOutput("txByte", {24'h0, O_TX_DATA}, {24'h0, expByte});
        end
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] word, input bit expectAll);
    fifoQ.push_back(word);
    expQ.push_back(word[7:0]);
    if (expectAll) expQ.push_back(word[15:8]);
  endtask

  task automatic waitQuiet(string name, int maxCycles);
    int n = 0;
    while (!(O_BUSY == 1'b0 && (fifoQ.size() == 0 || !I_EN) && txBusyModel == 1'b0 && O_R_INC == 1'b0)
           && n < maxCycles) begin
      @(posedge I_CLK);
      #2;
      n++;
    end
    if (n >= maxCycles) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: still busy after %0d cycles, required idle", name, maxCycles);
    end
  endtask

  task automatic waitValid(string name, int target, int maxCycles);
    int n = 0;
    while (validCount < target && n < maxCycles) begin
      @(posedge I_CLK);
      #2;
      n++;
    end
    if (n >= maxCycles) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: strobe count %0d after %0d cycles, required %0d", name, validCount, maxCycles, target);
    end
  endtask

  initial begin : mainSeq
    int v0;
    I_RST     = 1'b1;
    I_EN      = 1'b1;
    stallBusy = 1'b0;

    // Reset with a word already waiting and enable high: nothing may escape
    applyStimulus(16'hF0F0, 1'b1);
    repeat (3) @(posedge I_CLK);
    @(negedge I_CLK);
    checkOutput("rstRInc",    {31'h0, O_R_INC},    32'h0);
    checkOutput("rstTxValid", {31'h0, O_TX_VALID}, 32'h0);
    checkOutput("rstTxData",  {24'h0, O_TX_DATA},  32'h0);
    checkOutput("rstBusy",    {31'h0, O_BUSY},     32'h0);
    @(posedge I_CLK);
    #2 I_RST = 1'b0;

    // Single word 0xF0F0 and pop-to-strobe latency
    waitValid("singleFirst", 1, 20);
    checkOutput("latency", validCycle - popCycle, 32'd1);
    waitQuiet("single", 300);
    checkOutput("singlePops", popCount, 32'd1);
    checkOutput("singleBusy", {31'h0, O_BUSY}, 32'h0);
    checkOutput("singleLeft", expQ.size(), 32'd0);

    // Byte order
    applyStimulus(16'h00FF, 1'b1);
    waitQuiet("order", 300);
    checkOutput("orderPops", popCount, 32'd2);
    checkOutput("orderLeft", expQ.size(), 32'd0);

    // Three words back to back
    applyStimulus(16'hF0F0, 1'b1);
    applyStimulus(16'hF0FF, 1'b1);
    applyStimulus(16'h00FF, 1'b1);
    waitQuiet("b2b", 600);
    checkOutput("b2bPops",  popCount, 32'd5);
    checkOutput("b2bEmpty", {31'h0, I_EMPTY}, 32'h1);
    checkOutput("b2bLeft",  expQ.size(), 32'd0);

    // Transmitter held busy while a byte waits in SEND
    stallBusy = 1'b1;
    v0 = validCount;
    applyStimulus(16'hABCD, 1'b1);
    repeat (50) @(posedge I_CLK);
    #2;
    checkOutput("stallNoValid", validCount, v0);
    checkOutput("stallPops",    popCount, 32'd6);
    checkOutput("stallBusy",    {31'h0, O_BUSY}, 32'h1);
    stallBusy = 1'b0;
    repeat (5) @(posedge I_CLK);
    #2;
    checkOutput("stallOneStrobe", validCount, v0 + 1);
    waitQuiet("stall", 300);
    checkOutput("stallLeft", expQ.size(), 32'd0);

    // Enable dropped mid-word: word finishes, next word stays in FIFO
    v0 = validCount;
    applyStimulus(16'h1357, 1'b1);
    fifoQ.push_back(16'h2468);
    waitValid("enMidFirst", v0 + 1, 20);
    I_EN = 1'b0;
    waitQuiet("enMid", 300);
    checkOutput("enMidPops", popCount, 32'd7);
    checkOutput("enMidHeld", fifoQ.size(), 32'd1);
    checkOutput("enMidLeft", expQ.size(), 32'd0);
    repeat (20) @(posedge I_CLK);
    #2;
    checkOutput("enOffNoPop", popCount, 32'd7);
    checkOutput("enOffIdle",  {31'h0, O_BUSY}, 32'h0);
    expQ.push_back(8'h68);
    expQ.push_back(8'h24);
    I_EN = 1'b1;
    waitQuiet("enResume", 300);
    checkOutput("enResumePops", popCount, 32'd8);

    // Reset in the middle of 0x1234: the upper byte must never appear
    v0 = validCount;
    applyStimulus(16'h1234, 1'b0);
    waitValid("rstMidFirst", v0 + 1, 20);
    repeat (3) @(posedge I_CLK);
    #2 I_RST = 1'b1;
    @(negedge I_CLK);
    checkOutput("rstMidTxData",  {24'h0, O_TX_DATA},  32'h0);
    checkOutput("rstMidTxValid", {31'h0, O_TX_VALID}, 32'h0);
    checkOutput("rstMidBusy",    {31'h0, O_BUSY},     32'h0);
    checkOutput("rstMidRInc",    {31'h0, O_R_INC},    32'h0);
    @(posedge I_CLK);
    #2 I_RST = 1'b0;
    applyStimulus(16'h5678, 1'b1);
    waitQuiet("afterRst", 300);
    checkOutput("afterRstPops", popCount, 32'd10);
    checkOutput("afterRstLeft", expQ.size(), 32'd0);

`ifdef FIFO_RD_WORD_CNT_EN
    // Counter wrap from a forced 0xFFFF
    @(posedge I_CLK);
    #2 force dut.r_word_cnt = 16'hFFFF;
    @(posedge I_CLK);
    #2 release dut.r_word_cnt;
    applyStimulus(16'h0A0B, 1'b1);
    waitQuiet("cntWrap", 300);
    checkOutput("cntWrap", {16'h0, O_WORD_CNT}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
